multi_reg_transfer: RTL and testbench
=====================================

MULTI_REG_TRANSFER -- requirements
Module: multi_reg_transfer

Interface
REQ-001 SHALL have port: clock  in  1  single rising-edge clock for all state.
REQ-002 SHALL have port: not_reset  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  in  1  begin a block transfer; sampled only while idle.
REQ-004 SHALL have port: is_load  in  1  1 = LDM (memory to registers), 0 = STM (registers to memory).
REQ-005 SHALL have port: reg_list  in  15  bit n selects register rn (r0-r14); PC excluded.
REQ-006 SHALL have port: base_addr  in  32  word-aligned start address.
REQ-007 SHALL have port: busy  out  1  high from the cycle after start is accepted until done.
REQ-008 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port: final_addr  out  32  base_addr + 4*popcount(reg_list), valid with done, held until next start.
REQ-010 SHALL have ports: rf_sel_rd  out  4 and rf_rd_data  in  32  register-file read port; data valid one clock after select.
REQ-011 SHALL have ports: rf_sel_wr  out  4, rf_wr_data  out  32, rf_wr_en  out  1  register-file write port.
REQ-012 SHALL have ports: mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  32, mem_ack  in  1, mem_rdata  in  32.

Function
REQ-013 SHALL implement states IDLE, RD_REG, MEM, WR_REG, DONE.
REQ-014 SHALL, in IDLE with start=1, latch is_load, reg_list, base_addr; next state MEM (load) or RD_REG (store); DONE if reg_list=0.
REQ-015 SHALL ignore start whenever not in IDLE.
REQ-016 SHALL transfer selected registers in ascending index order, addresses base_addr, +4, +8, ... (increment-after).
REQ-017 SHALL, in RD_REG (one cycle), drive rf_sel_rd with the current register index, then enter MEM.
REQ-018 SHALL, in MEM, hold mem_req=1 with stable mem_addr, mem_we, mem_wdata until the cycle mem_ack=1; mem_ack outside MEM is ignored.
REQ-019 SHALL, for store, drive mem_we=1 and mem_wdata = rf_rd_data captured at MEM entry.
REQ-020 SHALL, for load, drive mem_we=0, capture mem_rdata on the ack cycle, and enter WR_REG.
REQ-021 SHALL, in WR_REG (one cycle), assert rf_wr_en=1 with rf_sel_wr = register index and rf_wr_data = captured data.
REQ-022 SHALL, after each completed register, clear its bit in the working list and advance to RD_REG/MEM for the next set bit, or DONE if none remain.
REQ-023 SHALL assert done=1 for exactly the DONE cycle, then return to IDLE; start is accepted again the cycle after DONE.
REQ-024 SHALL keep rf_wr_en=0 and mem_req=0 in all states other than WR_REG and MEM respectively.
REQ-025 SHALL compute addresses modulo 2^32 (wrap past 0xFFFFFFFC to 0x00000000).
REQ-026 SHALL take per register: store 2 cycles minimum (RD_REG + MEM with same-cycle ack), load 2 cycles minimum (MEM + WR_REG), plus ack wait cycles.

Reset
REQ-027 SHALL, while not_reset=0, immediately force state IDLE and all outputs to 0 (busy, done, mem_req, mem_we, rf_wr_en, all buses, final_addr).
REQ-028 SHALL abandon any in-progress transfer on reset; no write to memory or registers after reset assertion.

Verification
REQ-029 SHALL cover: STM reg_list=0x0005, base 0x100, r0=0xA, r2=0xB, ack immediate -> writes 0xA@0x100, 0xB@0x104; done at cycle 5 after start; final_addr=0x108.
REQ-030 SHALL cover: LDM reg_list=0x4001, base 0x200, mem returns 0x11, 0x22 -> r0=0x11, r14=0x22; final_addr=0x208.
REQ-031 SHALL cover: reg_list=0 -> no mem_req, no rf_wr_en; done one cycle after start; final_addr=base.
REQ-032 SHALL cover: mem_ack delayed 3 cycles -> mem_req, mem_addr, mem_wdata stable all 4 cycles; second start during busy ignored.
REQ-033 SHALL cover: not_reset low mid-MEM -> mem_req, busy drop without clock edge; no further writes; new transfer after release runs correctly.
REQ-034 SHALL cover: base 0xFFFFFFFC, two registers -> addresses 0xFFFFFFFC, 0x00000000; final_addr=0x00000004.

Source files
------------

// File: rtl/multi_reg_transfer_if.sv
// Memory-side bus of the block transfer engine: a request held until the
// slave acknowledges it.
interface multi_reg_transfer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/multi_reg_transfer.sv
// LDM/STM-style block transfer between a 15-entry register file (r0-r14)
// and memory, ascending register order with increment-after addressing.
module multi_reg_transfer (
    input  logic                 clock,
    input  logic                 not_reset,
    input  logic                 start,
    input  logic                 is_load,
    input  logic [14:0]          reg_list,
    input  logic [31:0]          base_addr,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          final_addr,
    output logic [3:0]           rf_sel_rd,
    input  logic [31:0]          rf_rd_data,
    output logic [3:0]           rf_sel_wr,
    output logic [31:0]          rf_wr_data,
    output logic                 rf_wr_en,
    multi_reg_transfer_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD_REG, MEM, WR_REG, DONE} state_t;

    state_t      state_reg;
    logic        load_reg;
    logic [14:0] list_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] final_addr_reg;
    logic [3:0]  rf_sel_rd_reg;
    logic [3:0]  rf_sel_wr_reg;
    logic [31:0] rf_wr_data_reg;
    logic        rf_wr_en_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] wdata_reg;
    logic        mem_first_reg;

    logic [3:0]  cur_idx;
    logic [3:0]  next_idx;
    logic [14:0] rest_list;
    logic        step_done;
    logic [31:0] byte_count;

    function automatic logic [3:0] lowest_idx(input logic [14:0] v);
        lowest_idx = 4'd0;
        for (int i = 14; i >= 0; i--) begin
            if (v[i]) lowest_idx = 4'(i);
        end
    endfunction

    always_comb begin
        cur_idx    = lowest_idx(list_reg);
        rest_list  = list_reg & (list_reg - 15'd1);
        next_idx   = lowest_idx(rest_list);
        step_done  = (state_reg == WR_REG) ||
                     ((state_reg == MEM) && bus.mem_ack && !load_reg);
        byte_count = 32'($countones(reg_list)) << 2;
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_reg      <= IDLE;
            load_reg       <= 1'b0;
            list_reg       <= 15'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            final_addr_reg <= 32'd0;
            rf_sel_rd_reg  <= 4'd0;
            rf_sel_wr_reg  <= 4'd0;
            rf_wr_data_reg <= 32'd0;
            rf_wr_en_reg   <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= 32'd0;
            wdata_reg      <= 32'd0;
            mem_first_reg  <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            rf_wr_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        load_reg       <= is_load;
                        list_reg       <= reg_list;
                        mem_addr_reg   <= base_addr;
                        final_addr_reg <= base_addr + byte_count;
                        mem_we_reg     <= !is_load;
                        busy_reg       <= 1'b1;
                        if (reg_list == 15'd0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else if (is_load) begin
                            state_reg   <= MEM;
                            mem_req_reg <= 1'b1;
                        end else begin
                            state_reg     <= RD_REG;
                            rf_sel_rd_reg <= lowest_idx(reg_list);
                        end
                    end
                end
                RD_REG: begin
                    state_reg     <= MEM;
                    mem_req_reg   <= 1'b1;
                    mem_first_reg <= 1'b1;
                end
                MEM: begin
                    // Register-file data arrives during the first MEM cycle;
                    // hold it so mem_wdata stays put while ack is pending.
                    mem_first_reg <= 1'b0;
                    if (mem_first_reg) wdata_reg <= rf_rd_data;
                    if (bus.mem_ack) begin
                        mem_req_reg <= 1'b0;
                        if (load_reg) begin
                            state_reg      <= WR_REG;
                            rf_wr_en_reg   <= 1'b1;
                            rf_sel_wr_reg  <= cur_idx;
                            rf_wr_data_reg <= bus.mem_rdata;
                        end
                    end
                end
                WR_REG: begin
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase

            // One register finished: drop its bit and move to the next one.
            if (step_done) begin
                list_reg     <= rest_list;
                mem_addr_reg <= mem_addr_reg + 32'd4;
                if (rest_list == 15'd0) begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end else if (load_reg) begin
                    state_reg   <= MEM;
                    mem_req_reg <= 1'b1;
                end else begin
                    state_reg     <= RD_REG;
                    rf_sel_rd_reg <= next_idx;
                end
            end
        end
    end

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign final_addr    = final_addr_reg;
    assign rf_sel_rd     = rf_sel_rd_reg;
    assign rf_sel_wr     = rf_sel_wr_reg;
    assign rf_wr_data    = rf_wr_data_reg;
    assign rf_wr_en      = rf_wr_en_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_first_reg ? rf_rd_data : wdata_reg;

endmodule

// File: tb/tb_multi_reg_transfer.sv
// Randomized bench for multi_reg_transfer: memory/register-file models plus a
// list-based reference of the expected memory and register traffic.
module tb_multi_reg_transfer;

    logic        clock = 1'b0;
    logic        not_reset = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic [14:0] reg_list = 15'd0;
    logic [31:0] base_addr = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] final_addr;
    logic [3:0]  rf_sel_rd;
    logic [31:0] rf_rd_data = 32'd0;
    logic [3:0]  rf_sel_wr;
    logic [31:0] rf_wr_data;
    logic        rf_wr_en;

    multi_reg_transfer_if bus();

    multi_reg_transfer dut (
        .clock      (clock),
        .not_reset  (not_reset),
        .start      (start),
        .is_load    (is_load),
        .reg_list   (reg_list),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .final_addr (final_addr),
        .rf_sel_rd  (rf_sel_rd),
        .rf_rd_data (rf_rd_data),
        .rf_sel_wr  (rf_sel_wr),
        .rf_wr_data (rf_wr_data),
        .rf_wr_en   (rf_wr_en),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } rfw_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rf [16];
    mem_t        obs_mem[$];
    mem_t        exp_mem[$];
    rfw_t        obs_rf[$];
    rfw_t        exp_rf[$];
    logic [31:0] load_q[$];
    int          ack_delay = 0;

    task automatic check_value(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Synchronous-read register file: data follows the select by one clock.
    initial begin
        forever begin
            @(posedge clock);
            rf_rd_data <= rf[rf_sel_rd];
        end
    end

    // Memory slave with programmable ack latency; records completed accesses
    // and register-file writes. Ack is toggled randomly while idle.
    initial begin
        int   wait_cnt;
        mem_t snap;
        wait_cnt = 0;
        snap = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clock);
            if (bus.mem_req) begin
                if (wait_cnt == 0)
                    snap = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
                else
                    check_value("mem_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, snap);
                if (wait_cnt >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    if (!bus.mem_we) begin
                        if (load_q.size() > 0) bus.mem_rdata = load_q.pop_front();
                        else bus.mem_rdata = 32'hDEAD_0000;
                    end
                    obs_mem.push_back({bus.mem_we, bus.mem_addr,
                                       bus.mem_we ? bus.mem_wdata : bus.mem_rdata});
                    wait_cnt = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
                wait_cnt = 0;
            end
            if (rf_wr_en) begin
                obs_rf.push_back({rf_sel_wr, rf_wr_data});
                rf[rf_sel_wr] = rf_wr_data;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_value({tag, "_ctrl"}, {busy, done, rf_wr_en, bus.mem_req, bus.mem_we, rf_sel_rd, rf_sel_wr}, 96'd0);
        check_value({tag, "_bus"}, {rf_wr_data, bus.mem_addr, bus.mem_wdata}, 96'd0);
        check_value({tag, "_final"}, final_addr, 96'd0);
    endtask

    task automatic run_transfer(input logic ld, input logic [14:0] list,
                                input logic [31:0] base, input int delay);
        int          k;
        int          cyc;
        int          exp_cycles;
        logic [31:0] addr;
        logic [31:0] exp_final;
        k = 0;
        exp_mem.delete();
        exp_rf.delete();
        obs_mem.delete();
        obs_rf.delete();
        for (int i = 0; i < 15; i++) begin
            if (list[i]) begin
                addr = base + 32'(4 * k);
                if (ld) begin
                    if (load_q.size() <= k) load_q.push_back($urandom);
                    exp_mem.push_back({1'b0, addr, load_q[k]});
                    exp_rf.push_back({4'(i), load_q[k]});
                end else begin
                    exp_mem.push_back({1'b1, addr, rf[i]});
                end
                k++;
            end
        end
        exp_cycles = 1 + k * (2 + delay);
        exp_final  = base + 32'(4 * k);
        ack_delay  = delay;

        @(negedge clock);
        start = 1'b1; is_load = ld; reg_list = list; base_addr = base;
        @(negedge clock);
        start = 1'b0;
        is_load = 1'($urandom); reg_list = 15'($urandom); base_addr = $urandom;
        cyc = 1;
        while (!done && cyc < 400) begin
            check_value("busy", busy, 1);
            if (cyc == 2) start = 1'b1;
            if (cyc == 3) start = 1'b0;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check_value("done", done, 1);
        check_value("done_cycle", cyc, exp_cycles);
        check_value("busy_at_done", busy, 1);
        check_value("final_addr", final_addr, exp_final);
        @(negedge clock);
        check_value("done_pulse", done, 0);
        check_value("idle_busy", busy, 0);
        check_value("final_hold", final_addr, exp_final);

        check_value("mem_count", obs_mem.size(), exp_mem.size());
        for (int i = 0; i < obs_mem.size() && i < exp_mem.size(); i++)
            check_value("mem_access", obs_mem[i], exp_mem[i]);
        check_value("rf_count", obs_rf.size(), exp_rf.size());
        for (int i = 0; i < obs_rf.size() && i < exp_rf.size(); i++)
            check_value("rf_write", obs_rf[i], exp_rf[i]);
        load_q.delete();
        $display("xfer %s list=%04h base=%08h delay=%0d regs=%0d cycles=%0d final=%08h",
                 ld ? "LDM" : "STM", list, base, delay, k, cyc, final_addr);
    endtask

    task automatic reset_mid_mem();
        int n;
        obs_mem.delete();
        obs_rf.delete();
        ack_delay = 8;
        @(negedge clock);
        start = 1'b1; is_load = 1'b0; reg_list = 15'h0013; base_addr = 32'h0000_0400;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!bus.mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_value("reach_mem", bus.mem_req, 1);
        @(negedge clock);
        #2 not_reset = 1'b0;
        #1 check_value("rst_mem_req", bus.mem_req, 0);
        check_value("rst_busy", busy, 0);
        check_all_zero("rst_async");
        repeat (3) @(negedge clock);
        check_value("abort_mem_writes", obs_mem.size(), 0);
        check_value("abort_rf_writes", obs_rf.size(), 0);
        not_reset = 1'b1;
        $display("xfer STM list=0013 base=00000400 aborted by reset");
    endtask

    initial begin
        logic        ld;
        logic [14:0] list;
        for (int i = 0; i < 16; i++) rf[i] = $urandom;

        #12 check_all_zero("reset");
        @(negedge clock);
        not_reset = 1'b1;

        rf[0] = 32'hA;
        rf[2] = 32'hB;
        run_transfer(1'b0, 15'h0005, 32'h0000_0100, 0);

        load_q.delete();
        load_q.push_back(32'h11);
        load_q.push_back(32'h22);
        run_transfer(1'b1, 15'h4001, 32'h0000_0200, 0);
        check_value("ldm_r0", rf[0], 32'h11);
        check_value("ldm_r14", rf[14], 32'h22);

        run_transfer(1'b0, 15'h0000, 32'h0000_0300, 0);
        run_transfer(1'b1, 15'h0000, 32'h1234_5670, 2);

        run_transfer(1'b0, 15'h0106, 32'h0000_0800, 3);
        run_transfer(1'b1, 15'h2080, 32'h0000_0900, 3);

        reset_mid_mem();
        run_transfer(1'b0, 15'h0013, 32'h0000_0400, 1);

        run_transfer(1'b0, 15'h0300, 32'hFFFF_FFFC, 0);
        run_transfer(1'b1, 15'h0410, 32'hFFFF_FFFC, 1);
        run_transfer(1'b0, 15'h7FFF, 32'hFFFF_FFF0, 0);

        for (int t = 0; t < 20; t++) begin
            ld   = 1'($urandom);
            list = (t % 5 == 4) ? 15'($urandom) & 15'($urandom) & 15'($urandom)
                                : 15'($urandom);
            run_transfer(ld, list, $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
